// File: rtl/mips_multicycle_if.sv
// rtl/mips_multicycle_if.sv - instruction-fetch and data-memory pin bundle of the multi-cycle MIPS core
interface mips_multicycle_if #(
  parameter int ADDR_W = 7
);
  logic [31:0]       IR_addr;
  logic [31:0]       IR;
  logic [31:0]       ReadDataMem;
  logic              mem_ready;
  logic              CEN;
  logic              WEN;
  logic              OEN;
  logic [ADDR_W-1:0] A;
  logic [31:0]       Data2Mem;
  logic              illegal;

  modport master (
    output IR_addr, CEN, WEN, OEN, A, Data2Mem, illegal,
    input  IR, ReadDataMem, mem_ready
  );

  modport slave (
    input  IR_addr, CEN, WEN, OEN, A, Data2Mem, illegal,
    output IR, ReadDataMem, mem_ready
  );
endinterface

// File: rtl/mips_multicycle.sv
// rtl/mips_multicycle.sv - multi-cycle MIPS core, FETCH/DECODE/EXEC/MEM/WB with variable-latency data memory
module mips_multicycle #(
  parameter int          ADDR_W   = 7,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  mips_multicycle_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  state_t      r_state;
  state_t      w_next;

  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_alu_out;
  logic [31:0] r_mdr;
  logic [31:0] r_target;
  logic [31:0] r_rf [32];

  logic [5:0]  w_op;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [4:0]  w_shamt;
  logic [5:0]  w_funct;
  logic [31:0] w_imm_sext;

  logic        w_is_rtype;
  logic        w_r_legal;
  logic        w_is_jr;
  logic        w_is_addi;
  logic        w_is_lw;
  logic        w_is_sw;
  logic        w_is_beq;
  logic        w_is_bne;
  logic        w_is_j;
  logic        w_is_jal;
  logic        w_legal;
  logic        w_taken;

  logic [31:0] w_alu;
  logic        w_rf_we;
  logic [4:0]  w_rf_waddr;
  logic [31:0] w_rf_wdata;

  logic        w_cen;
  logic        w_wen;
  logic        w_oen;
  logic        w_illegal;

  assign w_op       = r_ir[31:26];
  assign w_rs       = r_ir[25:21];
  assign w_rt       = r_ir[20:16];
  assign w_rd       = r_ir[15:11];
  assign w_shamt    = r_ir[10:6];
  assign w_funct    = r_ir[5:0];
  assign w_imm_sext = {{16{r_ir[15]}}, r_ir[15:0]};

  assign w_is_rtype = (w_op == OP_RTYPE);
  assign w_is_jr    = w_is_rtype && (w_funct == FN_JR);
  assign w_is_addi  = (w_op == OP_ADDI);
  assign w_is_lw    = (w_op == OP_LW);
  assign w_is_sw    = (w_op == OP_SW);
  assign w_is_beq   = (w_op == OP_BEQ);
  assign w_is_bne   = (w_op == OP_BNE);
  assign w_is_j     = (w_op == OP_J);
  assign w_is_jal   = (w_op == OP_JAL);

  always_comb begin
    w_r_legal = 1'b0;
    case (w_funct)
      FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_SLL, FN_SRL, FN_JR: w_r_legal = 1'b1;
      default:                                                      w_r_legal = 1'b0;
    endcase
  end

  assign w_legal = (w_is_rtype && w_r_legal) || w_is_addi || w_is_lw || w_is_sw ||
                   w_is_beq || w_is_bne || w_is_j || w_is_jal;

  assign w_taken = (r_a == r_b) ^ w_is_bne;

  // Non-R-type ALU users (addi, lw, sw) all want regA + sign-extended immediate.
  always_comb begin
    w_alu = r_a + w_imm_sext;
    if (w_is_rtype) begin
      case (w_funct)
        FN_ADD:  w_alu = r_a + r_b;
        FN_SUB:  w_alu = r_a - r_b;
        FN_AND:  w_alu = r_a & r_b;
        FN_OR:   w_alu = r_a | r_b;
        FN_SLT:  w_alu = ($signed(r_a) < $signed(r_b)) ? 32'd1 : 32'd0;
        FN_SLL:  w_alu = r_b << w_shamt;
        FN_SRL:  w_alu = r_b >> w_shamt;
        default: w_alu = r_a + r_b;
      endcase
    end
  end

  // Single write port shared by jal (link in EXEC) and ordinary write-back.
  always_comb begin
    w_rf_we    = 1'b0;
    w_rf_waddr = 5'd0;
    w_rf_wdata = 32'd0;
    if (r_state == S_EXEC && w_is_jal) begin
      w_rf_we    = 1'b1;
      w_rf_waddr = 5'd31;
      w_rf_wdata = r_pc;
    end else if (r_state == S_WB) begin
      w_rf_we    = 1'b1;
      w_rf_waddr = w_is_rtype ? w_rd : w_rt;
      w_rf_wdata = w_is_lw ? r_mdr : r_alu_out;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_cen     = 1'b1;
    w_wen     = 1'b1;
    w_oen     = 1'b1;
    w_illegal = 1'b0;
    case (r_state)
      S_FETCH: w_next = S_DECODE;
      S_DECODE: begin
        if (!w_legal) begin
          w_illegal = 1'b1;
          w_next    = S_FETCH;
        end else begin
          w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        if (w_is_lw || w_is_sw) begin
          w_next = S_MEM;
        end else if (w_is_beq || w_is_bne || w_is_j || w_is_jal || w_is_jr) begin
          w_next = S_FETCH;
        end else begin
          w_next = S_WB;
        end
      end
      S_MEM: begin
        w_cen = 1'b0;
        if (w_is_lw) begin
          w_oen = 1'b0;
        end else begin
          w_wen = 1'b0;
        end
        if (bus.mem_ready) begin
          w_next = w_is_lw ? S_WB : S_FETCH;
        end
      end
      S_WB:    w_next = S_FETCH;
      default: w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc      <= RESET_PC;
      r_ir      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_alu_out <= '0;
      r_mdr     <= '0;
      r_target  <= '0;
      for (int i = 0; i < 32; i++) begin
        r_rf[i] <= '0;
      end
    end else begin
      if (w_rf_we && (w_rf_waddr != 5'd0)) begin
        r_rf[w_rf_waddr] <= w_rf_wdata;
      end
      case (r_state)
        S_FETCH: begin
          r_ir <= bus.IR;
          r_pc <= r_pc + 32'd4;
        end
        S_DECODE: begin
          r_a      <= r_rf[w_rs];
          r_b      <= r_rf[w_rt];
          r_target <= r_pc + (w_imm_sext << 2);
        end
        S_EXEC: begin
          r_alu_out <= w_alu;
          if ((w_is_beq || w_is_bne) && w_taken) begin
            r_pc <= r_target;
          end else if (w_is_j || w_is_jal) begin
            r_pc <= {r_pc[31:28], r_ir[25:0], 2'b00};
          end else if (w_is_jr) begin
            r_pc <= r_a;
          end
        end
        S_MEM: begin
          if (bus.mem_ready && w_is_lw) begin
            r_mdr <= bus.ReadDataMem;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.IR_addr  = r_pc;
  assign bus.CEN      = w_cen;
  assign bus.WEN      = w_wen;
  assign bus.OEN      = w_oen;
  assign bus.A        = r_alu_out[ADDR_W-1:0];
  assign bus.Data2Mem = r_b;
  assign bus.illegal  = w_illegal;

endmodule

// File: tb/tb_mips_multicycle.sv
// tb/tb_mips_multicycle.sv - directed program run against mips_multicycle with hand-computed expectations
module tb_mips_multicycle;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  logic [31:0] rom [256];

  mips_multicycle_if #(.ADDR_W(7)) bus ();

  mips_multicycle #(.ADDR_W(7), .RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.IR = rom[bus.IR_addr[9:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ctl();
    return {29'd0, bus.CEN, bus.WEN, bus.OEN};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 256; i++) rom[i] = 32'h0000_0000;
    rom[8'h00] = 32'h2001_0005; // addi $1,$0,5
    rom[8'h01] = 32'h2002_0007; // addi $2,$0,7
    rom[8'h02] = 32'h0022_1820; // add  $3,$1,$2
    rom[8'h03] = 32'h0041_202A; // slt  $4,$2,$1
    rom[8'h04] = 32'h0022_2822; // sub  $5,$1,$2
    rom[8'h05] = 32'hAC03_0004; // sw   $3,4($0)
    rom[8'h06] = 32'h8C06_0004; // lw   $6,4($0)
    rom[8'h07] = 32'h1421_FFFF; // bne  $1,$1,-1
    rom[8'h08] = 32'h0C00_0040; // jal  0x40
    rom[8'h09] = 32'h1021_0001; // beq  $1,$1,+1
    rom[8'h0A] = 32'h2007_0009; // addi $7,$0,9 (skipped)
    rom[8'h0B] = 32'hFC00_0000; // opcode 0x3F
    rom[8'h0C] = 32'h2000_0001; // addi $0,$0,1
    rom[8'h0D] = 32'hAC03_0004; // sw   $3,4($0)
    rom[8'h40] = 32'h03E0_0008; // jr   $31

    rst_n           = 1'b0;
    bus.mem_ready   = 1'b0;
    bus.ReadDataMem = 32'h0;
    tick(2);
    chk("reset_pc", bus.IR_addr, 32'h0);
    chk("reset_ctl", ctl(), 32'h7);
    chk("reset_A", {25'd0, bus.A}, 32'h0);
    chk("reset_d2m", bus.Data2Mem, 32'h0);
    chk("reset_illegal", {31'd0, bus.illegal}, 32'h0);

    rst_n = 1'b1;
    chk("first_pc", bus.IR_addr, 32'h0);
    tick(1);
    chk("addi_pc4", bus.IR_addr, 32'h4);
    chk("addi_ctl0", ctl(), 32'h7);
    for (int i = 1; i < 4; i++) begin
      tick(1);
      chk("addi_ctl", ctl(), 32'h7);
    end
    chk("addi_r1", dut.r_rf[1], 32'd5);

    tick(16);
    chk("r2", dut.r_rf[2], 32'd7);
    chk("add_r3", dut.r_rf[3], 32'd12);
    chk("slt_r4", dut.r_rf[4], 32'd0);
    chk("sub_r5", dut.r_rf[5], 32'hFFFF_FFFE);
    chk("pc_sw", bus.IR_addr, 32'h14);

    tick(3);
    for (int i = 0; i < 4; i++) begin
      chk("sw_ctl", ctl(), 32'h1);
      chk("sw_A", {25'd0, bus.A}, 32'd4);
      chk("sw_d2m", bus.Data2Mem, 32'd12);
      if (i == 3) bus.mem_ready = 1'b1;
      tick(1);
    end
    bus.mem_ready = 1'b0;
    chk("sw_done_ctl", ctl(), 32'h7);
    chk("sw_done_pc", bus.IR_addr, 32'h18);

    bus.ReadDataMem = 32'hDEAD_BEEF;
    bus.mem_ready   = 1'b1;
    tick(3);
    chk("lw_ctl", ctl(), 32'h2);
    chk("lw_A", {25'd0, bus.A}, 32'd4);
    tick(1);
    chk("lw_wb_ctl", ctl(), 32'h7);
    tick(1);
    bus.mem_ready = 1'b0;
    chk("lw_r6", dut.r_rf[6], 32'hDEAD_BEEF);
    chk("lw_pc", bus.IR_addr, 32'h1C);

    tick(3);
    chk("bne_pc", bus.IR_addr, 32'h20);
    tick(3);
    chk("jal_pc", bus.IR_addr, 32'h100);
    chk("jal_r31", dut.r_rf[31], 32'h24);
    tick(3);
    chk("jr_pc", bus.IR_addr, 32'h24);
    tick(3);
    chk("beq_pc", bus.IR_addr, 32'h2C);
    chk("beq_skip_r7", dut.r_rf[7], 32'd0);

    tick(1);
    chk("illegal_hi", {31'd0, bus.illegal}, 32'h1);
    tick(1);
    chk("illegal_lo", {31'd0, bus.illegal}, 32'h0);
    chk("illegal_pc", bus.IR_addr, 32'h30);
    chk("illegal_r1", dut.r_rf[1], 32'd5);
    chk("illegal_r6", dut.r_rf[6], 32'hDEAD_BEEF);
    chk("illegal_r7", dut.r_rf[7], 32'd0);

    tick(4);
    chk("r0_zero", dut.r_rf[0], 32'd0);
    chk("r0_pc", bus.IR_addr, 32'h34);

    tick(4);
    chk("mem_wait_ctl", ctl(), 32'h1);
    rst_n = 1'b0;
    tick(1);
    chk("rst_mem_ctl", ctl(), 32'h7);
    chk("rst_mem_pc", bus.IR_addr, 32'h0);
    chk("rst_mem_r1", dut.r_rf[1], 32'd0);
    rst_n = 1'b1;
    tick(1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
